// File: rtl/tug_pkg.sv
// Tug-of-war match controller: shared state encoding, defaults and helpers.
package tug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_PLAY,
    ST_ROUND_END,
    ST_MATCH_OVER
  } tug_state_e;

  // Default match configuration
  localparam int unsigned WIN_ROUNDS    = 3;
  localparam int unsigned COUNTDOWN_CYC = 8;

  // Datapath widths
  localparam int unsigned SCORE_W = 3;
  localparam int unsigned CNT_W   = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Increment a score, sticking at the display maximum instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tug_match_ctrl_round_timer.sv
// Loadable down-counter with zero flag, used for the pre-round hold.
module round_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Load has priority over decrement; decrement never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/tug_match_ctrl.sv
// Tug-of-war match sequencer: countdown, pull arbitration, scoring, match end.
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int unsigned WIN_ROUNDS    = tug_pkg::WIN_ROUNDS,
  parameter int unsigned COUNTDOWN_CYC = tug_pkg::COUNTDOWN_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               human_pull,
  input  logic               cpu_pull,
  input  logic               round_win_l,
  input  logic               round_win_r,
  output logic               pull_l,
  output logic               pull_r,
  output logic               field_clr,
  output logic               play_en,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               winner_r
);

  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_ROUNDS);
  localparam logic [CNT_W-1:0]   CD_LOAD   = CNT_W'(COUNTDOWN_CYC - 1);

  tug_state_e         state_q, state_d;
  logic               start_q;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               pull_l_q, pull_l_d;
  logic               pull_r_q, pull_r_d;

  logic               start_edge;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;
  logic [CNT_W-1:0]   tmr_count;

  assign start_edge = start & ~start_q;

  round_timer #(
    .CNT_W (CNT_W)
  ) u_round_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (CD_LOAD),
    .dec_i      (tmr_dec),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  // Next-state, scoring, timer control and pull arbitration
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    pull_l_d  = 1'b0;
    pull_r_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_MATCH_OVER: begin
        if (start_edge) begin
          score_l_d = '0;
          score_r_d = '0;
          tmr_load  = 1'b1;
          state_d   = ST_COUNTDOWN;
        end
      end

      ST_COUNTDOWN: begin
        if (tmr_zero) begin
          state_d = ST_PLAY;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_PLAY: begin
        // A simultaneous win on both edges is a draw: no score change
        if (round_win_r && !round_win_l) begin
          score_r_d = sat_inc(score_r_q);
        end else if (round_win_l && !round_win_r) begin
          score_l_d = sat_inc(score_l_q);
        end
        if (round_win_l || round_win_r) begin
          state_d = ST_ROUND_END;
        end else begin
          // Grants only while staying in PLAY, so none lands after exit
          pull_r_d = human_pull & ~cpu_pull;
          pull_l_d = cpu_pull & ~human_pull;
        end
      end

      ST_ROUND_END: begin
        if ((score_l_q == WIN_SCORE) || (score_r_q == WIN_SCORE)) begin
          state_d = ST_MATCH_OVER;
        end else begin
          tmr_load = 1'b1;
          state_d  = ST_COUNTDOWN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, start-edge history, scores and registered pull grants
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      pull_l_q  <= 1'b0;
      pull_r_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      pull_l_q  <= pull_l_d;
      pull_r_q  <= pull_r_d;
    end
  end

  // State-decoded outputs
  always_comb begin
    field_clr  = (state_q == ST_IDLE) || (state_q == ST_COUNTDOWN) ||
                 (state_q == ST_ROUND_END);
    play_en    = (state_q == ST_PLAY);
    match_over = (state_q == ST_MATCH_OVER);
    winner_r   = (state_q == ST_MATCH_OVER) && (score_r_q == WIN_SCORE);
  end

  assign pull_l  = pull_l_q;
  assign pull_r  = pull_r_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule
